// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, framing constants and bit-period helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        LINE_IDLE = 1'b1;

    // Clock cycles per serial bit (integer division, truncating).
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Restartable modulo-CLKS_PER_BIT counter marking the end of each serial bit period.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_end_c,
    output logic o_pre_end_c
);

    localparam int unsigned       CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  PRE   = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Pre-end strobe lets a consumer register a flag that lands on the last cycle.
    assign o_bit_end_c = i_enable && (r_cnt == LAST);
    assign o_pre_end_c = i_enable && (r_cnt == PRE);

endmodule

// File: rtl/uart_byte_tx.sv
// Serial byte transmitter: start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD_RATE    = 115_200,
    parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_byte_send_en,
    input  logic [7:0] i_tx_data,
    input  logic       i_parity_en,
    input  logic       i_parity_odd,
    input  logic       i_stop2,
    output logic       o_tx_serial,
    output logic       o_tx_busy,
    output logic       o_byte_tx_done
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_byte_tx: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    tx_state_e            r_state;
    tx_state_e            w_state_nxt;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_idx_nxt;
    logic                 r_stop_idx;
    logic                 w_stop_idx_nxt;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_par_en;
    logic                 r_par_odd;
    logic                 r_stop2;
    logic                 r_tx_serial;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_accept;
    logic                 w_line_nxt;
    logic                 w_done_nxt;
    logic                 w_bit_end;
    logic                 w_pre_end;
    logic                 w_parity;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_accept),
        .i_enable    (r_state != IDLE),
        .o_bit_end_c (w_bit_end),
        .o_pre_end_c (w_pre_end)
    );

    assign w_parity = (^r_data) ^ r_par_odd;

    // State register; serial line, busy and done are registered from next-state values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_tx_serial <= LINE_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_stop_idx  <= w_stop_idx_nxt;
            r_tx_serial <= w_line_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= w_done_nxt;
        end
    end

    // Frame settings are frozen at accept so mid-frame input changes are ignored.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_data    <= i_tx_data;
            r_par_en  <= i_parity_en;
            r_par_odd <= i_parity_odd;
            r_stop2   <= i_stop2;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_accept       = 1'b0;
        w_done_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_byte_send_en) begin
                    w_accept       = 1'b1;
                    w_state_nxt    = START;
                    w_bit_idx_nxt  = '0;
                    w_stop_idx_nxt = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                        w_state_nxt = r_par_en ? PARITY : STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                // Done is flagged one cycle early so the registered pulse hits the last stop cycle.
                w_done_nxt = w_pre_end && (r_stop_idx == r_stop2);
                if (w_bit_end) begin
                    if (r_stop_idx == r_stop2) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_line_nxt = LINE_IDLE;
        case (w_state_nxt)
            START:   w_line_nxt = 1'b0;
            DATA:    w_line_nxt = r_data[w_bit_idx_nxt];
            PARITY:  w_line_nxt = w_parity;
            default: w_line_nxt = LINE_IDLE;
        endcase
    end

    assign o_tx_serial    = r_tx_serial;
    assign o_tx_busy      = r_busy;
    assign o_byte_tx_done = r_done;

endmodule
